// File: rtl/flag_unit.sv
// Processor flag register with a small LIFO save stack and a condition-code evaluator.
// COND is a pure function of CC and the registered flags.
module flag_unit #(
    parameter int DEPTH = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       SIGN_IN,
    input  logic       CARRY_IN,
    input  logic       ZERO_IN,
    input  logic       PARITY_IN,
    input  logic       LATCH,
    input  logic       LOAD,
    input  logic [3:0] LOAD_DATA,
    input  logic       PUSH,
    input  logic       POP,
    input  logic [3:0] CC,
    output logic [3:0] FLAGS,
    output logic       COND,
    output logic       EMPTY,
    output logic       FULL,
    output logic       ERR
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    logic [3:0]    flags_r;
    logic [DW-1:0] depth_r;
    logic          err_r;
    logic [3:0]    stack_r [DEPTH];

    logic          push_only_s;
    logic          pop_only_s;
    logic          do_push_s;
    logic          do_pop_s;
    logic          err_set_s;
    logic          empty_s;
    logic          full_s;
    logic [AW-1:0] wr_idx_s;
    logic [AW-1:0] top_idx_s;
    logic [3:0]    top_s;
    logic [3:0]    flags_next_s;
    logic [DW-1:0] depth_next_s;

    // Condition evaluation over flags {S,C,Z,P}
    function automatic logic cond_eval(input logic [3:0] cc, input logic [3:0] f);
        logic s;
        logic c;
        logic z;
        logic p;
        logic r;
        s = f[3];
        c = f[2];
        z = f[1];
        p = f[0];
        case (cc)
            4'd0:    r = 1'b1;
            4'd1:    r = z;
            4'd2:    r = ~z;
            4'd3:    r = c;
            4'd4:    r = ~c;
            4'd5:    r = s;
            4'd6:    r = ~s;
            4'd7:    r = p;
            4'd8:    r = ~p;
            4'd9:    r = s ^ p;
            4'd10:   r = ~(s ^ p);
            4'd11:   r = ~c & ~z;
            4'd12:   r = c | z;
            4'd13:   r = ~z & ~(s ^ p);
            4'd14:   r = z | (s ^ p);
            4'd15:   r = 1'b0;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    assign empty_s     = (depth_r == DW'(0));
    assign full_s      = (depth_r == DW'(DEPTH));
    // Simultaneous PUSH and POP cancel each other and never raise an error
    assign push_only_s = PUSH & ~POP;
    assign pop_only_s  = POP & ~PUSH;
    assign do_push_s   = push_only_s & ~full_s;
    assign do_pop_s    = pop_only_s & ~empty_s;
    assign err_set_s   = (push_only_s & full_s) | (pop_only_s & empty_s);
    assign wr_idx_s    = depth_r[AW-1:0];
    assign top_idx_s   = AW'(depth_r - DW'(1));
    assign top_s       = stack_r[top_idx_s];

    // Next flag value and stack depth
    always_comb begin
        flags_next_s = flags_r;
        depth_next_s = depth_r;
        if (do_pop_s) begin
            flags_next_s = top_s;
        end else if (LOAD) begin
            flags_next_s = LOAD_DATA;
        end else if (LATCH) begin
            flags_next_s = {SIGN_IN, CARRY_IN, ZERO_IN, PARITY_IN};
        end else begin
            flags_next_s = flags_r;
        end
        if (do_push_s) begin
            depth_next_s = depth_r + DW'(1);
        end else if (do_pop_s) begin
            depth_next_s = depth_r - DW'(1);
        end else begin
            depth_next_s = depth_r;
        end
    end

    // Flag register, depth counter and sticky error
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            flags_r <= 4'b0000;
            depth_r <= DW'(0);
            err_r   <= 1'b0;
        end else begin
            flags_r <= flags_next_s;
            depth_r <= depth_next_s;
            err_r   <= err_r | err_set_s;
        end
    end

    // Stack storage; entries above the depth pointer are unreachable, so no reset
    always_ff @(posedge CLK) begin
        if (do_push_s) begin
            stack_r[wr_idx_s] <= flags_r;
        end
    end

    assign FLAGS = flags_r;
    assign EMPTY = empty_s;
    assign FULL  = full_s;
    assign ERR   = err_r;
    assign COND  = cond_eval(CC, flags_r);

endmodule

// File: tb/tb_flag_unit.sv
// Directed table-driven bench for flag_unit (DEPTH=4) plus reset and CC-sweep sequences.
module tb_flag_unit;

    logic       CLK;
    logic       RESET;
    logic       SIGN_IN, CARRY_IN, ZERO_IN, PARITY_IN;
    logic       LATCH, LOAD, PUSH, POP;
    logic [3:0] LOAD_DATA;
    logic [3:0] CC;
    logic [3:0] FLAGS;
    logic       COND, EMPTY, FULL, ERR;

    int checks = 0;
    int errors = 0;

    flag_unit #(.DEPTH(4)) dut (
        .CLK(CLK), .RESET(RESET),
        .SIGN_IN(SIGN_IN), .CARRY_IN(CARRY_IN), .ZERO_IN(ZERO_IN), .PARITY_IN(PARITY_IN),
        .LATCH(LATCH), .LOAD(LOAD), .LOAD_DATA(LOAD_DATA),
        .PUSH(PUSH), .POP(POP), .CC(CC),
        .FLAGS(FLAGS), .COND(COND), .EMPTY(EMPTY), .FULL(FULL), .ERR(ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic       latch;
        logic       load;
        logic [3:0] ld;
        logic       push;
        logic       pop;
        logic [3:0] ins;
        logic [3:0] ef;
        logic       ee;
        logic       efu;
        logic       eer;
    } vec_t;

    vec_t vecs [19];

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_status(input string tag, input logic [3:0] ef,
                                input logic ee, input logic efu, input logic eer);
        check({tag, " FLAGS"}, FLAGS, ef);
        check({tag, " EMPTY"}, {3'b000, EMPTY}, {3'b000, ee});
        check({tag, " FULL"},  {3'b000, FULL},  {3'b000, efu});
        check({tag, " ERR"},   {3'b000, ERR},   {3'b000, eer});
    endtask

    // Apply controls for one rising edge, then return them to idle 1 ns later
    task automatic step(input logic lt, input logic ld, input logic [3:0] d,
                        input logic pu, input logic po, input logic [3:0] ins);
        LATCH = lt; LOAD = ld; LOAD_DATA = d; PUSH = pu; POP = po;
        {SIGN_IN, CARRY_IN, ZERO_IN, PARITY_IN} = ins;
        @(posedge CLK);
        #1;
        LATCH = 1'b0; LOAD = 1'b0; LOAD_DATA = 4'h0; PUSH = 1'b0; POP = 1'b0;
        {SIGN_IN, CARRY_IN, ZERO_IN, PARITY_IN} = 4'b0000;
    endtask

    function automatic logic ref_cond(input logic [3:0] cc, input logic [3:0] f);
        logic s, c, z, p, lt;
        s = f[3]; c = f[2]; z = f[1]; p = f[0];
        lt = (s != p);
        if (cc == 4'd0)       return 1'b1;
        else if (cc == 4'd1)  return z;
        else if (cc == 4'd2)  return !z;
        else if (cc == 4'd3)  return c;
        else if (cc == 4'd4)  return !c;
        else if (cc == 4'd5)  return s;
        else if (cc == 4'd6)  return !s;
        else if (cc == 4'd7)  return p;
        else if (cc == 4'd8)  return !p;
        else if (cc == 4'd9)  return lt;
        else if (cc == 4'd10) return !lt;
        else if (cc == 4'd11) return !(c || z);
        else if (cc == 4'd12) return c || z;
        else if (cc == 4'd13) return !z && !lt;
        else if (cc == 4'd14) return z || lt;
        else                  return 1'b0;
    endfunction

    initial begin
        //            latch load  ld    push  pop   ins    ef    ee    full  err
        vecs[0]  = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 4'hA, 4'hA, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 4'h3, 1'b0, 1'b0, 4'h0, 4'h3, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 4'h3, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 4'hC, 1'b0, 1'b0, 4'h0, 4'hC, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 4'hC, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 4'h0, 4'hC, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 4'h0, 4'h3, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 4'h1, 1'b1, 1'b0, 4'h0, 4'h1, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 4'h2, 1'b1, 1'b0, 4'h0, 4'h2, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 4'h4, 1'b1, 1'b0, 4'h0, 4'h4, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 4'h8, 1'b1, 1'b0, 4'h0, 4'h8, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 4'h5, 1'b1, 1'b0, 4'h0, 4'h5, 1'b0, 1'b1, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 4'h0, 4'h4, 1'b0, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 4'h0, 4'h2, 1'b0, 1'b0, 1'b1};
        vecs[14] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 4'h0, 4'h1, 1'b0, 1'b0, 1'b1};
        vecs[15] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 4'h0, 4'h3, 1'b1, 1'b0, 1'b1};
        vecs[16] = '{1'b0, 1'b1, 4'h6, 1'b1, 1'b0, 4'h0, 4'h6, 1'b0, 1'b0, 1'b1};
        vecs[17] = '{1'b1, 1'b1, 4'hF, 1'b0, 1'b1, 4'hF, 4'h3, 1'b1, 1'b0, 1'b1};
        vecs[18] = '{1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 4'h6, 4'h6, 1'b1, 1'b0, 1'b1};

        RESET = 1'b1;
        LATCH = 1'b0; LOAD = 1'b0; LOAD_DATA = 4'h0; PUSH = 1'b0; POP = 1'b0; CC = 4'd0;
        {SIGN_IN, CARRY_IN, ZERO_IN, PARITY_IN} = 4'b0000;
        #1;
        check_status("reset", 4'h0, 1'b1, 1'b0, 1'b0);
        @(negedge CLK);
        RESET = 1'b0;

        for (int i = 0; i < 19; i++) begin
            step(vecs[i].latch, vecs[i].load, vecs[i].ld, vecs[i].push, vecs[i].pop, vecs[i].ins);
            check_status($sformatf("vec%0d", i), vecs[i].ef, vecs[i].ee, vecs[i].efu, vecs[i].eer);
            if (i == 0) begin
                CC = 4'd1; #1;
                check("cond cc1 on A", {3'b000, COND}, 4'd1);
                CC = 4'd2; #1;
                check("cond cc2 on A", {3'b000, COND}, 4'd0);
            end
        end

        // Asynchronous reset between edges clears sticky error and flags at once
        #2 RESET = 1'b1;
        #1 check_status("async reset", 4'h0, 1'b1, 1'b0, 1'b0);
        @(negedge CLK);
        RESET = 1'b0;

        // Underflow with LATCH in the same cycle, then PUSH+POP no-op
        step(1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 4'b1100);
        check_status("pop empty+latch", 4'hC, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 4'h0);
        check_status("push+pop empty", 4'hC, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0);
        step(1'b0, 1'b1, 4'h9, 1'b0, 1'b0, 4'h0);
        step(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 4'h0);
        check_status("push+pop depth1", 4'h9, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 4'h0);
        check_status("pop after no-op", 4'hC, 1'b1, 1'b0, 1'b1);

        // Reset in the middle of a push sequence
        #2 RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        step(1'b0, 1'b1, 4'h7, 1'b0, 1'b0, 4'h0);
        step(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0);
        step(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0);
        check_status("two pushes", 4'h7, 1'b0, 1'b0, 1'b0);
        PUSH = 1'b1;
        #2 RESET = 1'b1;
        #1 check_status("reset mid push", 4'h0, 1'b1, 1'b0, 1'b0);
        @(posedge CLK);
        #1 check_status("reset held", 4'h0, 1'b1, 1'b0, 1'b0);
        PUSH = 1'b0;
        @(negedge CLK);
        RESET = 1'b0;
        step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 4'h0);
        check_status("pop after reset", 4'h0, 1'b1, 1'b0, 1'b1);

        // Full CC x FLAGS sweep; LOAD_DATA is scrambled to show COND ignores it
        for (int f = 0; f < 16; f++) begin
            step(1'b0, 1'b1, 4'(f), 1'b0, 1'b0, 4'h0);
            check($sformatf("sweep load %0d", f), FLAGS, 4'(f));
            for (int c = 0; c < 16; c++) begin
                CC = 4'(c);
                LOAD_DATA = 4'(15 - f);
                {SIGN_IN, CARRY_IN, ZERO_IN, PARITY_IN} = 4'(~f);
                #1;
                check($sformatf("cond f=%0d cc=%0d", f, c), {3'b000, COND},
                      {3'b000, ref_cond(4'(c), 4'(f))});
            end
        end
        step(1'b0, 1'b1, 4'b1000, 1'b0, 1'b0, 4'h0);
        CC = 4'd9; #1;
        check("cond 1000 cc9", {3'b000, COND}, 4'd1);
        CC = 4'd13; #1;
        check("cond 1000 cc13", {3'b000, COND}, 4'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
